// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH    = 32
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [OPERAND_WIDTH-1:0] req_wdata;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [OPERAND_WIDTH-1:0] rsp_rdata;
    logic                     rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency, byte/half/word access with
// sign/zero extension and error flagging for misaligned, out-of-range or illegal-size requests.
module dmem_responder #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned LATENCY       = 1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WordIdxW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     write_q, write_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [OPERAND_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]               size_q, size_d;
    logic                     uns_q, uns_d;
    logic [OPERAND_WIDTH-1:0] rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic [OPERAND_WIDTH-1:0] mem_q [DEPTH];
    logic                     mem_we;
    logic [OPERAND_WIDTH-1:0] mem_wdata;

    logic [WordIdxW-1:0]      widx;
    logic [1:0]               lane;
    logic [OPERAND_WIDTH-1:0] rd_word;
    logic [OPERAND_WIDTH-1:0] shifted;
    logic [OPERAND_WIDTH-1:0] ld_val;
    logic [OPERAND_WIDTH-1:0] wrep;
    logic [3:0]               be;
    logic                     acc_err;

    // Access datapath, evaluated on the latched request.
    always_comb begin
        widx    = addr_q[ADDR_WIDTH-1:2];
        lane    = addr_q[1:0];
        rd_word = mem_q[widx[IdxW-1:0]];
        shifted = rd_word >> {lane, 3'b000};
        acc_err = (size_q == 2'b11)
                | ((size_q == 2'b01) & addr_q[0])
                | ((size_q == 2'b10) & (lane != 2'b00))
                | (widx >= WordIdxW'(DEPTH));
        ld_val  = rd_word;
        be      = 4'b1111;
        wrep    = wdata_q;
        unique case (size_q)
            2'b00: begin
                ld_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
                be     = 4'b0001 << lane;
                wrep   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                ld_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
                be     = 4'b0011 << lane;
                wrep   = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        mem_wdata = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_wdata[i*8 +: 8] = wrep[i*8 +: 8];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Commit edge: errors suppress both the write and the read data.
                    mem_we  = write_q & ~acc_err;
                    rdata_d = (write_q | acc_err) ? '0 : ld_val;
                    err_d   = acc_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[widx[IdxW-1:0]] <= mem_wdata;
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_rdata = rdata_q;
        bus.rsp_error = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=1 and a LATENCY=4 instance, a byte-level memory model
// checked every cycle, plus directed loads/stores with hand-computed expected results.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic        req_valid_t[2], req_write_t[2], req_unsigned_t[2], rsp_ready_t[2];
    logic [31:0] req_addr_t[2], req_wdata_t[2];
    logic [1:0]  req_size_t[2];
    logic        req_ready_w[2], rsp_valid_w[2], rsp_error_w[2];
    logic [31:0] rsp_rdata_w[2];

    dmem_responder_if #(.OPERAND_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    dmem_responder_if #(.OPERAND_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

    assign bus0.req_valid    = req_valid_t[0];
    assign bus0.req_write    = req_write_t[0];
    assign bus0.req_addr     = req_addr_t[0];
    assign bus0.req_wdata    = req_wdata_t[0];
    assign bus0.req_size     = req_size_t[0];
    assign bus0.req_unsigned = req_unsigned_t[0];
    assign bus0.rsp_ready    = rsp_ready_t[0];
    assign bus1.req_valid    = req_valid_t[1];
    assign bus1.req_write    = req_write_t[1];
    assign bus1.req_addr     = req_addr_t[1];
    assign bus1.req_wdata    = req_wdata_t[1];
    assign bus1.req_size     = req_size_t[1];
    assign bus1.req_unsigned = req_unsigned_t[1];
    assign bus1.rsp_ready    = rsp_ready_t[1];
    assign req_ready_w[0] = bus0.req_ready;
    assign rsp_valid_w[0] = bus0.rsp_valid;
    assign rsp_rdata_w[0] = bus0.rsp_rdata;
    assign rsp_error_w[0] = bus0.rsp_error;
    assign req_ready_w[1] = bus1.req_ready;
    assign rsp_valid_w[1] = bus1.rsp_valid;
    assign rsp_rdata_w[1] = bus1.rsp_rdata;
    assign rsp_error_w[1] = bus1.rsp_error;

    dmem_responder #(.OPERAND_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    dmem_responder #(.OPERAND_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Byte-addressed reference memory and the one outstanding transaction per instance.
    logic [7:0]  mem_m [2][4*DEPTH];
    logic        pend[2];
    int          acc[2];
    logic [31:0] exp_rdata[2];
    logic        exp_err[2];
    logic        p_wr[2];
    logic [31:0] p_addr[2], p_wdata[2];
    logic [1:0]  p_size[2];

    function automatic void model_access(input int d, input logic wr, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns,
                                         output logic [31:0] rdata, output logic err);
        int     nb;
        longint v;
        nb    = 1 << size;
        err   = (size == 2'b11) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
        rdata = 32'h0;
        if (!err && !wr) begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (longint'(mem_m[d][int'(addr) + k]) << (8 * k));
            if (!uns && nb < 4 && (((v >> (8 * nb - 1)) & 1) == 1))
                v = v - (longint'(1) << (8 * nb));
            rdata = v[31:0];
        end
    endfunction

    always @(posedge clk) begin : p_model
        logic [31:0] r;
        logic        e;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (pend[d] && (cyc - acc[d] >= lat_of(d)) && rsp_ready_t[d]) begin
                    pend[d] <= 1'b0;
                    if (p_wr[d] && !exp_err[d])
                        for (int k = 0; k < (1 << p_size[d]); k++)
                            mem_m[d][int'(p_addr[d]) + k] <= p_wdata[d][8*k +: 8];
                end else if (!pend[d] && req_valid_t[d]) begin
                    model_access(d, req_write_t[d], req_addr_t[d], req_size_t[d],
                                 req_unsigned_t[d], r, e);
                    pend[d]      <= 1'b1;
                    acc[d]       <= cyc + 1;
                    exp_rdata[d] <= r;
                    exp_err[d]   <= e;
                    p_wr[d]      <= req_write_t[d];
                    p_addr[d]    <= req_addr_t[d];
                    p_wdata[d]   <= req_wdata_t[d];
                    p_size[d]    <= req_size_t[d];
                end
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge rst_n) begin
        pend[0] <= 1'b0;
        pend[1] <= 1'b0;
    end

    always @(negedge clk) begin : p_compare
        logic rv;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_rsp_valid", d, 32'(rsp_valid_w[d]), 32'h0);
                chk("rst_req_ready", d, 32'(req_ready_w[d]), 32'h1);
            end else begin
                rv = pend[d] && (cyc - acc[d] >= lat_of(d));
                chk("req_ready", d, 32'(req_ready_w[d]), 32'(!pend[d]));
                chk("rsp_valid", d, 32'(rsp_valid_w[d]), 32'(rv));
                chk("rsp_rdata", d, rsp_rdata_w[d], rv ? exp_rdata[d] : 32'h0);
                chk("rsp_error", d, 32'(rsp_error_w[d]), rv ? 32'(exp_err[d]) : 32'h0);
            end
        end
    end

    task automatic start_req(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        bit ok;
        @(posedge clk);
        #1;
        req_write_t[d]    = wr;
        req_addr_t[d]     = addr;
        req_wdata_t[d]    = wdata;
        req_size_t[d]     = size;
        req_unsigned_t[d] = uns;
        req_valid_t[d]    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready_w[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", d, 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_valid_t[d] = 1'b0;
    endtask

    task automatic finish_rsp(input int d, input int hold, output logic [31:0] rdata,
                              output logic err, output int lat);
        lat   = -1;
        rdata = 32'hx;
        err   = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid_w[d]) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            chk("rsp_timeout", d, 32'h0, 32'h1);
            return;
        end
        rdata = rsp_rdata_w[d];
        err   = rsp_error_w[d];
        repeat (hold) @(negedge clk);
        #1;
        rsp_ready_t[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_t[d] = 1'b0;
    endtask

    task automatic req(input string name, input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input int hold, input logic [31:0] want_rdata, input logic want_err);
        logic [31:0] r;
        logic        e;
        int          lat;
        start_req(d, wr, addr, wdata, size, uns);
        finish_rsp(d, hold, r, e, lat);
        chk({name, "_rdata"}, d, r, want_rdata);
        chk({name, "_err"}, d, 32'(e), 32'(want_err));
        chk({name, "_lat"}, d, lat, lat_of(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            req_valid_t[d] = 1'b0;
            req_write_t[d] = 1'b0;
            req_addr_t[d] = 32'h0;
            req_wdata_t[d] = 32'h0;
            req_size_t[d] = 2'b00;
            req_unsigned_t[d] = 1'b0;
            rsp_ready_t[d] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #2;
        chk("reset_req_ready", 0, 32'(req_ready_w[0]), 32'h1);
        chk("reset_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'h0);
        chk("reset_rsp_rdata", 0, rsp_rdata_w[0], 32'h0);
        chk("reset_rsp_error", 0, 32'(rsp_error_w[0]), 32'h0);
        #19 rst_n = 1'b1;

        // LATENCY = 1 instance: word store/load, extension, partial stores, errors.
        req("sw_10",     0, 1'b1, 32'h10,   32'hDEADBEEF, 2'b10, 1'b0, 0, 32'h0,        1'b0);
        req("lw_10",     0, 1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        req("lb_13_s",   0, 1'b0, 32'h13,   32'h0,        2'b00, 1'b0, 0, 32'hFFFFFFDE, 1'b0);
        req("lb_13_u",   0, 1'b0, 32'h13,   32'h0,        2'b00, 1'b1, 0, 32'h000000DE, 1'b0);
        req("lh_10_s",   0, 1'b0, 32'h10,   32'h0,        2'b01, 1'b0, 0, 32'hFFFFBEEF, 1'b0);
        req("lh_10_u",   0, 1'b0, 32'h10,   32'h0,        2'b01, 1'b1, 0, 32'h0000BEEF, 1'b0);
        req("sb_11",     0, 1'b1, 32'h11,   32'hAAAAAA55, 2'b00, 1'b0, 0, 32'h0,        1'b0);
        req("lw_10_b",   0, 1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 0, 32'hDEAD55EF, 1'b0);
        req("sh_12",     0, 1'b1, 32'h12,   32'h12348001, 2'b01, 1'b0, 0, 32'h0,        1'b0);
        req("lw_10_h",   0, 1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 0, 32'h800155EF, 1'b0);
        req("lh_12_s",   0, 1'b0, 32'h12,   32'h0,        2'b01, 1'b0, 0, 32'hFFFF8001, 1'b0);
        req("lb_11_u",   0, 1'b0, 32'h11,   32'h0,        2'b00, 1'b1, 0, 32'h00000055, 1'b0);
        req("lh_11_mis", 0, 1'b0, 32'h11,   32'h0,        2'b01, 1'b0, 0, 32'h0,        1'b1);
        req("sw_0",      0, 1'b1, 32'h0,    32'hCAFEF00D, 2'b10, 1'b0, 0, 32'h0,        1'b0);
        req("sw_oor",    0, 1'b1, 32'h1000, 32'h11111111, 2'b10, 1'b0, 0, 32'h0,        1'b1);
        req("lw_0",      0, 1'b0, 32'h0,    32'h0,        2'b10, 1'b0, 0, 32'hCAFEF00D, 1'b0);
        req("size_11",   0, 1'b0, 32'h0,    32'h0,        2'b11, 1'b0, 0, 32'h0,        1'b1);
        req("sw_3_mis",  0, 1'b1, 32'h3,    32'h22222222, 2'b10, 1'b0, 0, 32'h0,        1'b1);
        req("lw_0_b",    0, 1'b0, 32'h0,    32'h0,        2'b10, 1'b0, 0, 32'hCAFEF00D, 1'b0);

        // Reset while a response is pending: rsp_valid drops asynchronously, storage survives.
        start_req(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        @(posedge clk);
        #2;
        chk("resp_before_rst", 0, 32'(rsp_valid_w[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("resp_async_drop", 0, 32'(rsp_valid_w[0]), 32'h0);
        chk("resp_rst_ready", 0, 32'(req_ready_w[0]), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        req("lw_10_rst", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 32'h800155EF, 1'b0);

        // LATENCY = 4 instance: exact latency and back-pressure.
        req("l4_sw_40",  1, 1'b1, 32'h40, 32'h0BADF00D, 2'b10, 1'b0, 0, 32'h0,        1'b0);
        req("l4_lw_40",  1, 1'b0, 32'h40, 32'h0,        2'b10, 1'b0, 3, 32'h0BADF00D, 1'b0);
        req("l4_lb_42",  1, 1'b0, 32'h42, 32'h0,        2'b00, 1'b0, 2, 32'hFFFFFFAD, 1'b0);
        req("l4_sw_20",  1, 1'b1, 32'h20, 32'h0,        2'b10, 1'b0, 0, 32'h0,        1'b0);

        // Reset in BUSY discards the uncommitted store.
        start_req(1, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("busy_rst_valid", 1, 32'(rsp_valid_w[1]), 32'h0);
        chk("busy_rst_ready", 1, 32'(req_ready_w[1]), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        req("l4_lw_20",  1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
